// File: rtl/led_scan_timing_ctrl.sv
// HUB75 scan-timing controller: pixel/row counters, latch, brightness-scaled
// output enable, PWM compare counter, frame-start pulse and AL422 pointer reset.
// Optional feature macro: LED_BRIGHTNESS_EN (per-row sampled global brightness).
module led_scan_timing_ctrl #(
    parameter int unsigned PIXEL_COUNT    = 64,
    parameter int unsigned ROW_COUNT      = 16,
    parameter int unsigned PWM_WIDTH      = 8,
    parameter int unsigned PIXEL_PRELOAD  = 2,
    parameter int unsigned PWM_CORRECTION = 0,
    parameter int unsigned OE_PREDELAY    = 2,
    parameter int unsigned OE_POSTDELAY   = 2
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic       shift_stb,
    input  logic       pwm_stb,
    input  logic       alrst_stb,
    input  logic [7:0] brightness,
    output logic       led_lat,
    output logic       led_oe,
    output logic [4:0] led_row,
    output logic [7:0] pwm_cntr,
    output logic       al422_nrst,
    output logic       frame_start
);

    localparam int unsigned PC_W    = $clog2(PIXEL_COUNT);
    localparam int unsigned ROW_W   = $clog2(ROW_COUNT);
    localparam int unsigned OFF_W   = PC_W + 1;
    localparam int unsigned PL      = (PIXEL_COUNT - (PIXEL_PRELOAD % PIXEL_COUNT)) % PIXEL_COUNT;
    localparam int unsigned RL      = ROW_COUNT - 2;
    localparam int unsigned MAX     = (1 << PWM_WIDTH) - 2;
    localparam int unsigned AL_PIX  = (PL + PIXEL_COUNT - 1) % PIXEL_COUNT;
    localparam int unsigned PWM_PIX = (PL + PWM_CORRECTION) % PIXEL_COUNT;
    localparam int          N_PIX   = int'(PIXEL_COUNT) - int'(OE_PREDELAY) - int'(OE_POSTDELAY);

    // Reject geometries with no lit window or a set point outside the row
    if (N_PIX < 1 || OE_POSTDELAY >= PIXEL_COUNT) begin : g_param_check
        $error("led_scan_timing_ctrl: need PIXEL_COUNT - OE_PREDELAY - OE_POSTDELAY >= 1 and OE_POSTDELAY < PIXEL_COUNT");
    end

    logic [PC_W-1:0]      r_pix;
    logic [ROW_W-1:0]     r_row;
    logic [PWM_WIDTH-1:0] r_pwm;
    logic                 r_oe;
    logic                 r_al_n;
    logic                 r_fs;

    logic                 w_lat;
    logic                 w_last_row;
    logic                 w_pwm_step;
    logic                 w_pwm_wrap;
    logic                 w_al_hit;
    logic [OFF_W-1:0]     w_oe_off;

    assign w_lat      = shift_stb & (r_pix == PC_W'(PIXEL_COUNT - 1));
    assign w_last_row = (r_row == ROW_W'(RL));
    assign w_pwm_step = pwm_stb & (r_pix == PC_W'(PWM_PIX)) & w_last_row;
    assign w_pwm_wrap = (r_pwm == PWM_WIDTH'(MAX));
    assign w_al_hit   = alrst_stb & (r_pix == PC_W'(AL_PIX)) & w_last_row;

`ifdef LED_BRIGHTNESS_EN
    localparam int unsigned PROD_W = PC_W + 9;

    logic [7:0]        r_bright;
    logic [PROD_W-1:0] w_prod;

    // Brightness is sampled at the latch so it stays constant across a row
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_bright <= 8'd255;
        end else if (w_lat) begin
            r_bright <= brightness;
        end
    end

    assign w_prod   = PROD_W'(N_PIX) * PROD_W'({1'b0, r_bright} + 9'd1);
    assign w_oe_off = OFF_W'(OE_POSTDELAY) + OFF_W'(w_prod >> 8);
`else
    logic w_unused_brightness;

    assign w_unused_brightness = ^brightness;
    assign w_oe_off            = OFF_W'(PIXEL_COUNT - OE_PREDELAY);
`endif

    // Pixel position within the row, started at the decoder preload offset
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_pix <= PC_W'(PL);
        end else if (shift_stb) begin
            r_pix <= (r_pix == PC_W'(PIXEL_COUNT - 1)) ? '0 : r_pix + PC_W'(1);
        end
    end

    // Row address advances with every latch
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_row <= ROW_W'(RL);
        end else if (w_lat) begin
            r_row <= (r_row == ROW_W'(ROW_COUNT - 1)) ? '0 : r_row + ROW_W'(1);
        end
    end

    // Output-enable window; clear wins so an empty window keeps OE low
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_oe <= 1'b0;
        end else if ({1'b0, r_pix} == w_oe_off) begin
            r_oe <= 1'b0;
        end else if (r_pix == PC_W'(OE_POSTDELAY)) begin
            r_oe <= 1'b1;
        end
    end

    // PWM compare counter steps once per frame, skipping the all-ones value
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_pwm <= PWM_WIDTH'(MAX);
            r_fs  <= 1'b0;
        end else begin
            r_fs <= w_pwm_step & w_pwm_wrap;
            if (w_pwm_step) begin
                r_pwm <= w_pwm_wrap ? '0 : r_pwm + PWM_WIDTH'(1);
            end
        end
    end

    // AL422 read-pointer reset, one low cycle per qualifying request
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_al_n <= 1'b1;
        end else begin
            r_al_n <= ~w_al_hit;
        end
    end

    assign led_lat     = w_lat;
    assign led_oe      = r_oe;
    assign led_row     = 5'(r_row);
    assign pwm_cntr    = 8'(r_pwm);
    assign al422_nrst  = r_al_n;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_led_scan_timing_ctrl.sv
// Scoreboard bench for led_scan_timing_ctrl (8 pixels, 8 rows, 2-bit PWM).
module tb_led_scan_timing_ctrl;

    localparam int P    = 8;
    localparam int R    = 8;
    localparam int PW   = 2;
    localparam int PRE  = 2;
    localparam int POST = 2;
    localparam int PRL  = 2;
    localparam int CORR = 0;

    localparam int PL      = (P - PRL) % P;
    localparam int RL      = R - 2;
    localparam int MAXV    = (1 << PW) - 2;
    localparam int NWIN    = P - PRE - POST;
    localparam int AL_PIX  = (PL + P - 1) % P;
    localparam int PWM_PIX = (PL + CORR) % P;

    logic       in_clk = 1'b0;
    logic       in_nrst = 1'b0;
    logic       shift_stb = 1'b0;
    logic       pwm_stb = 1'b0;
    logic       alrst_stb = 1'b0;
    logic [7:0] brightness = 8'd255;
    logic       led_lat;
    logic       led_oe;
    logic [4:0] led_row;
    logic [7:0] pwm_cntr;
    logic       al422_nrst;
    logic       frame_start;

    led_scan_timing_ctrl #(
        .PIXEL_COUNT(P), .ROW_COUNT(R), .PWM_WIDTH(PW), .PIXEL_PRELOAD(PRL),
        .PWM_CORRECTION(CORR), .OE_PREDELAY(PRE), .OE_POSTDELAY(POST)
    ) dut (
        .in_clk(in_clk), .in_nrst(in_nrst), .shift_stb(shift_stb), .pwm_stb(pwm_stb),
        .alrst_stb(alrst_stb), .brightness(brightness), .led_lat(led_lat), .led_oe(led_oe),
        .led_row(led_row), .pwm_cntr(pwm_cntr), .al422_nrst(al422_nrst), .frame_start(frame_start)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        int lat;
        int oe;
        int row;
        int pwm;
        int al;
        int fs;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model: everything derived from total shifts and PWM steps
    int m_shifts;
    int m_steps;
    int m_bright;
    int m_oe;
    int m_al;
    int m_fs;

    function automatic int m_pix();
        return (PL + m_shifts) % P;
    endfunction

    function automatic int m_row();
        return (RL + (PL + m_shifts) / P) % R;
    endfunction

    function automatic int m_oe_off();
`ifdef LED_BRIGHTNESS_EN
        return POST + (NWIN * (m_bright + 1)) / 256;
`else
        return P - PRE;
`endif
    endfunction

    function automatic void model_reset();
        m_shifts = 0;
        m_steps  = 0;
        m_bright = 255;
        m_oe     = 0;
        m_al     = 1;
        m_fs     = 0;
    endfunction

    function automatic void model_advance(input int sh, input int pw, input int al, input int br);
        int pix;
        int row;
        int step;
        pix   = m_pix();
        row   = m_row();
        step  = (pw != 0 && pix == PWM_PIX && row == RL) ? 1 : 0;
        m_oe  = (pix >= POST && pix < m_oe_off()) ? 1 : 0;
        m_al  = (al != 0 && pix == AL_PIX && row == RL) ? 0 : 1;
        m_fs  = 0;
        if (step != 0) begin
            m_steps++;
            m_fs = ((m_steps % (MAXV + 1)) == 1) ? 1 : 0;
        end
        if (sh != 0 && pix == P - 1) m_bright = br;
        if (sh != 0) m_shifts++;
    endfunction

    // One clock of stimulus: drive, record expectation, advance the model
    task automatic cycle(input logic rn, input logic sh, input logic pw, input logic al, input logic [7:0] br);
        exp_t e;
        @(posedge in_clk);
        #1;
        in_nrst    = rn;
        shift_stb  = sh;
        pwm_stb    = pw;
        alrst_stb  = al;
        brightness = br;
        if (!rn) model_reset();
        e.lat = (sh && m_pix() == P - 1) ? 1 : 0;
        e.oe  = m_oe;
        e.row = m_row();
        e.pwm = (MAXV + m_steps) % (MAXV + 1);
        e.al  = m_al;
        e.fs  = m_fs;
        sb_q.push_back(e);
        if (rn) model_advance(int'(sh), int'(pw), int'(al), int'(br));
    endtask

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge in_clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("led_lat", int'(led_lat), mon_e.lat);
            check("led_oe", int'(led_oe), mon_e.oe);
            check("led_row", int'(led_row), mon_e.row);
            check("pwm_cntr", int'(pwm_cntr), mon_e.pwm);
            check("al422_nrst", int'(al422_nrst), mon_e.al);
            check("frame_start", int'(frame_start), mon_e.fs);
        end
    end

    logic [7:0] br_cur;
    int         found;

    initial begin
        model_reset();
        // Reset state, then the first latch after the preload pulses
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'd255);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd255);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd255);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd255);

        // Full brightness with PWM and AL422 requests held
        for (int i = 0; i < 400; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd255);

        // Dark rows, then a mid-row change to half brightness
        for (int i = 0; i < 200; i++)
            cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd127);

        // Random strobes with gaps and changing brightness
        br_cur = 8'd200;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: br_cur = 8'd0;
                    1: br_cur = 8'd127;
                    2: br_cur = 8'd255;
                    default: br_cur = 8'($urandom_range(0, 255));
                endcase
            end
            cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), br_cur);
        end

        // Asynchronous reset at row 3, pixel 4
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (m_row() == 3 && m_pix() == 4) found = 1;
            else cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd127);
        end
        check("reach_row3_pix4", found, 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'd127);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'd127);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd127);
        for (int i = 0; i < 800; i++)
            cycle(1'b1, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

        @(negedge in_clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
